// File: rtl/apb_btn_event_pkg.sv
// Shared definitions for the APB button event block.
// Holds the register offsets, the STATUS/CLEAR/EVENT bit positions, the
// decoded register-select enum and the address decode helper.
package apb_btn_event_pkg;

    // Register byte offsets.
    localparam logic [31:0] OFF_STATUS = 32'h0;
    localparam logic [31:0] OFF_CLEAR  = 32'h4;
    localparam logic [31:0] OFF_EVENT  = 32'h8;
    localparam logic [31:0] OFF_COUNT  = 32'hC;

    // STATUS field positions.
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;
    localparam int STAT_COUNT_LSB = 16;
    localparam int STAT_COUNT_W   = 4;

    // CLEAR: bit that clears the overflow flag.
    localparam int CLR_OVF_BIT = 8;

    // EVENT: valid flag position.
    localparam int EVT_VALID_BIT = 31;

    // COUNT: four 8-bit counter fields, button 0 in the low byte.
    localparam int CNT_FIELD_W = 8;
    localparam int CNT_FIELDS  = 4;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_CLEAR,
        REG_EVENT,
        REG_COUNT,
        REG_NONE
    } reg_e;

    function automatic reg_e decode_addr(input logic [31:0] addr);
        case (addr)
            OFF_STATUS: return REG_STATUS;
            OFF_CLEAR:  return REG_CLEAR;
            OFF_EVENT:  return REG_EVENT;
            OFF_COUNT:  return REG_COUNT;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO holding button indices.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   push/wr_data write request and button index
//   pop          read request (ignored when empty)
//   rd_data      head entry (valid when !empty)
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
module btn_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, the slot being vacated by the pop is the one written.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/apb_btn_event.sv
// APB slave collecting single-cycle button press pulses.
// Per button: sticky pending flag, 8-bit wrapping press counter and a
// one-deep stage feeding an ordered event FIFO; o_irq = |pending.
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   i_btn               press pulses, one clk wide, synchronous to clk
//   PADDR/PSEL/PENABLE  APB address and handshake
//   PWRITE/PWDATA       APB write control and data
//   PRDATA              registered read data, loaded in the setup phase
//   PREADY              high in the cycle after setup (zero wait states)
//   o_irq               level interrupt, any pending flag set
module apb_btn_event
    import apb_btn_event_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic [ADDR_W-1:0]  PADDR,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               o_irq
);

    localparam int IDX_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int FCNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_FIELDS = (NUM_BTN < CNT_FIELDS) ? NUM_BTN : CNT_FIELDS;

    logic [NUM_BTN-1:0]     pending;
    logic [NUM_BTN-1:0]     stage;
    logic [CNT_FIELD_W-1:0] cnt [NUM_BTN];
    logic                   overflow;
    logic                   pop_armed;

    reg_e                   sel;
    logic                   setup;
    logic                   access;
    logic                   wr_clear;
    logic                   wr_count;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [IDX_W-1:0]       fifo_head;
    logic [IDX_W-1:0]       push_idx;
    logic [FCNT_W-1:0]      fifo_count;

    logic [NUM_BTN-1:0]     drain_src;
    logic [NUM_BTN-1:0]     drain_onehot;
    logic [NUM_BTN-1:0]     stage_drained;
    logic [NUM_BTN-1:0]     bypass_drained;
    logic [NUM_BTN-1:0]     stage_rem;
    logic [NUM_BTN-1:0]     lost;
    logic [31:0]            rdata;

    logic                   unused_pwdata;
    assign unused_pwdata = ^PWDATA;

    assign sel      = decode_addr(32'(PADDR));
    assign setup    = PSEL & ~PENABLE;
    assign access   = PSEL & PENABLE & PREADY;
    assign wr_clear = access & PWRITE & (sel == REG_CLEAR);
    assign wr_count = access & PWRITE & (sel == REG_COUNT);
    // Pop only if the setup phase actually returned a valid entry; an entry
    // arriving between setup and access must not be consumed unseen.
    assign fifo_pop = access & ~PWRITE & (sel == REG_EVENT) & pop_armed;
    assign o_irq    = |pending;

    // Priority drain: the lowest-index staged button goes to the FIFO. With
    // nothing staged, a fresh press bypasses the stage for 1-cycle latency.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        drain_src    = (stage != '0) ? stage : i_btn;
        drain_onehot = drain_src & (~drain_src + NUM_BTN'(1));
        push_idx     = '0;
        for (int b = NUM_BTN - 1; b >= 0; b--) begin
            if (drain_src[b]) push_idx = IDX_W'(b);
        end
        fifo_push      = (|drain_src) & (~fifo_full | fifo_pop);
        stage_drained  = (fifo_push && stage != '0) ? drain_onehot : '0;
        bypass_drained = (fifo_push && stage == '0) ? drain_onehot : '0;
        stage_rem      = stage & ~stage_drained;
        // A press only loses an event if its staged predecessor is still waiting.
        lost           = i_btn & stage_rem;
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_STATUS: begin
                rdata[NUM_BTN-1:0]                       = pending;
                rdata[STAT_EMPTY_BIT]                    = fifo_empty;
                rdata[STAT_FULL_BIT]                     = fifo_full;
                rdata[STAT_OVF_BIT]                      = overflow;
                rdata[STAT_COUNT_LSB +: STAT_COUNT_W]    = STAT_COUNT_W'(fifo_count);
            end
            REG_EVENT: begin
                if (!fifo_empty) begin
                    rdata[EVT_VALID_BIT] = 1'b1;
                    rdata[IDX_W-1:0]     = fifo_head;
                end
            end
            REG_COUNT: begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    rdata[i*CNT_FIELD_W +: CNT_FIELD_W] = cnt[i];
                end
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            pop_armed <= 1'b0;
            pending   <= '0;
            stage     <= '0;
            overflow  <= 1'b0;
            for (int b = 0; b < NUM_BTN; b++) cnt[b] <= '0;
        end else begin
            PREADY <= setup;
            if (setup) begin
                PRDATA    <= PWRITE ? '0 : rdata;
                pop_armed <= ~PWRITE & (sel == REG_EVENT) & ~fifo_empty;
            end
            // Presses are OR-ed in after the clear, so a new press wins.
            pending <= (wr_clear ? (pending & ~PWDATA[NUM_BTN-1:0]) : pending) | i_btn;
            for (int b = 0; b < NUM_BTN; b++) begin
                if (i_btn[b])     cnt[b] <= (wr_count ? '0 : cnt[b]) + CNT_FIELD_W'(1);
                else if (wr_count) cnt[b] <= '0;
            end
            stage    <= stage_rem | (i_btn & ~bypass_drained);
            overflow <= (overflow & ~(wr_clear & PWDATA[CLR_OVF_BIT])) | (|lost);
        end
    end

    btn_evt_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (push_idx),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
